// File: rtl/upscaler_pkg.sv
// Shared types and helpers for the pixel replicator and its upscaler neighbours.
// Holds the default pixel width, the replicator state encoding and a counter-width helper.
package upscaler_pkg;

  localparam int PIX_W = 24;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    EMIT = 2'd1,
    GAP  = 2'd2
  } state_e;

  // Width of a counter that takes values 0..n_values-1; never narrower than one bit.
  function automatic int cnt_w(input int n_values);
    return (n_values <= 1) ? 1 : $clog2(n_values);
  endfunction

endpackage

// File: rtl/pixel_replicator_tx_if.sv
// Native-pixel input handshake plus the replicated stream that drives top_upscaler.
// The master side is the pixel source and upscaler; the slave side is the replicator.
interface pixel_replicator_tx_if #(
  parameter int PIX_W = upscaler_pkg::PIX_W
);

  logic [PIX_W-1:0] s_pixel;
  logic             s_valid;
  logic             s_ready;
  logic [PIX_W-1:0] pixel_out;
  logic             output_valid;
  logic             frame_done;
  logic             busy;

  modport master (
    output s_pixel,
    output s_valid,
    input  s_ready,
    input  pixel_out,
    input  output_valid,
    input  frame_done,
    input  busy
  );

  modport slave (
    input  s_pixel,
    input  s_valid,
    output s_ready,
    output pixel_out,
    output output_valid,
    output frame_done,
    output busy
  );

endinterface

// File: rtl/pixel_line_buffer.sv
// One native row of pixels: synchronous write port and a registered read port.
// The read register doubles as the replicator's pixel_out and holds when rd_en_i is low.
module pixel_line_buffer #(
  parameter int DEPTH = 128,
  parameter int WIDTH = 24,
  parameter int AW    = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // NOTE: the storage array has no reset so it maps onto plain RAM; its contents are only
  // read after a full row has been written.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Write-first bypass covers a one-pixel row, where the last write and first read collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= (wr_en_i && (wr_addr_i == rd_addr_i)) ? wr_data_i : mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/pixel_replicator_tx.sv
// Buffers one native row, then replays it SCALE times with each pixel repeated SCALE times,
// inserting one idle cycle after every output row; the stream feeds top_upscaler directly.
module pixel_replicator_tx
  import upscaler_pkg::*;
#(
  parameter int IMG_W = 128,
  parameter int IMG_H = 72,
  parameter int SCALE = 3,
  parameter int PIX_W = upscaler_pkg::PIX_W
) (
  input logic                 clk,
  input logic                 rst_n,
  pixel_replicator_tx_if.slave bus
);

  localparam int CW = cnt_w(IMG_W);
  localparam int RW = cnt_w(SCALE);
  localparam int HW = cnt_w(IMG_H);

  localparam logic [CW-1:0] LAST_COL  = CW'(IMG_W - 1);
  localparam logic [RW-1:0] LAST_REP  = RW'(SCALE - 1);
  localparam logic [RW-1:0] LAST_LINE = RW'(SCALE - 1);
  localparam logic [HW-1:0] LAST_ROW  = HW'(IMG_H - 1);

  state_e           state_q;
  logic [CW-1:0]    col_q;
  logic [RW-1:0]    rep_q;
  logic [RW-1:0]    line_q;
  logic [HW-1:0]    row_q;
  logic             valid_q;
  logic             frame_done_q;

  logic             accept;
  logic             rd_en;
  logic [CW-1:0]    rd_addr;
  logic [PIX_W-1:0] rd_data;

  assign accept = (state_q == FILL) && bus.s_valid;

  // Read port is addressed with the pixel of the *next* beat so that rd_data lands
  // in the same cycle as valid_q.
  // NOTE: every output of this block gets a default first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    rd_en   = 1'b0;
    rd_addr = '0;
    unique case (state_q)
      FILL: rd_en = accept && (col_q == LAST_COL);
      EMIT: begin
        if (!((rep_q == LAST_REP) && (col_q == LAST_COL))) begin
          rd_en   = 1'b1;
          rd_addr = (rep_q == LAST_REP) ? col_q + 1'b1 : col_q;
        end
      end
      GAP:  rd_en = (line_q != LAST_LINE);
      default: rd_en = 1'b0;
    endcase
  end

  // Outputs are registered alongside the state, so output_valid is high exactly while
  // the state is EMIT and frame_done coincides with the last GAP of the frame.
  // NOTE: all state here updates with non-blocking assignments so every branch sees the
  // pre-edge values of the counters it compares against.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FILL;
      col_q        <= '0;
      rep_q        <= '0;
      line_q       <= '0;
      row_q        <= '0;
      valid_q      <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      unique case (state_q)
        FILL: begin
          if (bus.s_valid) begin
            if (col_q == LAST_COL) begin
              col_q   <= '0;
              state_q <= EMIT;
              valid_q <= 1'b1;
            end else begin
              col_q <= col_q + 1'b1;
            end
          end
        end

        EMIT: begin
          if (rep_q != LAST_REP) begin
            rep_q <= rep_q + 1'b1;
          end else begin
            rep_q <= '0;
            if (col_q != LAST_COL) begin
              col_q <= col_q + 1'b1;
            end else begin
              col_q        <= '0;
              state_q      <= GAP;
              valid_q      <= 1'b0;
              frame_done_q <= (line_q == LAST_LINE) && (row_q == LAST_ROW);
            end
          end
        end

        GAP: begin
          if (line_q != LAST_LINE) begin
            line_q  <= line_q + 1'b1;
            state_q <= EMIT;
            valid_q <= 1'b1;
          end else begin
            line_q  <= '0;
            state_q <= FILL;
            row_q   <= (row_q == LAST_ROW) ? '0 : row_q + 1'b1;
          end
        end

        default: begin
          state_q <= FILL;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  pixel_line_buffer #(
    .DEPTH (IMG_W),
    .WIDTH (PIX_W),
    .AW    (CW)
  ) u_line_buffer (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (accept),
    .wr_addr_i (col_q),
    .wr_data_i (bus.s_pixel),
    .rd_en_i   (rd_en),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  assign bus.s_ready      = (state_q == FILL);
  assign bus.busy         = (state_q != FILL);
  assign bus.output_valid = valid_q;
  assign bus.frame_done   = frame_done_q;
  assign bus.pixel_out    = rd_data;

endmodule

// File: tb/tb_pixel_replicator_tx.sv
// Bench for pixel_replicator_tx: a SCALE=3 and a SCALE=1 instance (4x2 image) are driven with
// directed and random rows and compared cycle by cycle against a row-expansion reference model.
module tb_pixel_replicator_tx;

  localparam int W = 4;
  localparam int H = 2;

  typedef logic [23:0] pix_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pixel_replicator_tx_if #(.PIX_W(24)) bus3 ();
  pixel_replicator_tx_if #(.PIX_W(24)) bus1 ();

  pixel_replicator_tx #(.IMG_W(W), .IMG_H(H), .SCALE(3), .PIX_W(24)) u_dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3)
  );

  pixel_replicator_tx #(.IMG_W(W), .IMG_H(H), .SCALE(1), .PIX_W(24)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int row_pos[2];   // model's view of the native row index within the frame, per instance
  int beats_seen;
  int fd_seen;

  pix_t row_px[W];
  // Expected and observed per-cycle tuples: {valid, pixel, frame_done, s_ready, busy}
  logic [27:0] exp_q[$];
  logic [27:0] obs_q[$];

  function automatic logic [27:0] pack(input logic v, input pix_t p, input logic fd,
                                       input logic rdy, input logic bsy);
    return {v, p, fd, rdy, bsy};
  endfunction

  // Reference: one native row becomes SCALE output rows, each pixel repeated SCALE times and
  // followed by one idle cycle that holds the last pixel. frame_done marks the final idle
  // cycle of the last native row.
  function automatic void model_row(input int scale, input bit last_row);
    exp_q.delete();
    for (int l = 0; l < scale; l++) begin
      for (int c = 0; c < W; c++)
        for (int r = 0; r < scale; r++)
          exp_q.push_back(pack(1'b1, row_px[c], 1'b0, 1'b0, 1'b1));
      exp_q.push_back(pack(1'b0, row_px[W-1], last_row && (l == scale - 1), 1'b0, 1'b1));
    end
  endfunction

  function automatic logic [27:0] sample(input bit sel);
    if (sel) return pack(bus1.output_valid, bus1.pixel_out, bus1.frame_done, bus1.s_ready, bus1.busy);
    return pack(bus3.output_valid, bus3.pixel_out, bus3.frame_done, bus3.s_ready, bus3.busy);
  endfunction

  task automatic drive(input bit sel, input logic v, input pix_t p);
    if (sel) begin
      bus1.s_valid = v;
      bus1.s_pixel = p;
    end else begin
      bus3.s_valid = v;
      bus3.s_pixel = p;
    end
  endtask

  // Presents row_px on one instance, optionally idling stall_len cycles before pixel
  // stall_before; returns just after the edge that accepts the last pixel.
  task automatic feed(input bit sel, input int stall_before, input int stall_len, input string name);
    logic [27:0] s;
    for (int i = 0; i < W; i++) begin
      if (i == stall_before) begin
        for (int k = 0; k < stall_len; k++) begin
          @(negedge clk);
          s = sample(sel);
          n_tests++;
          if (s[27] !== 1'b0 || s[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL %s stall%0d: valid=%0b s_ready=%0b, expected valid=0 s_ready=1", name, k, s[27], s[1]);
          end
          drive(sel, 1'b0, '0);
        end
      end
      @(negedge clk);
      s = sample(sel);
      n_tests++;
      if (s[27] !== 1'b0 || s[1] !== 1'b1) begin
        n_fail++;
        $display("FAIL %s fill%0d: valid=%0b s_ready=%0b, expected valid=0 s_ready=1", name, i, s[27], s[1]);
      end
      drive(sel, 1'b1, row_px[i]);
    end
    @(posedge clk);
    #1 drive(sel, 1'b0, '0);
  endtask

  task automatic capture(input bit sel, input int ncyc);
    obs_q.delete();
    repeat (ncyc) begin
      @(negedge clk);
      obs_q.push_back(sample(sel));
    end
  endtask

  // Feeds row_px, captures the whole expansion and scores it against the model.
  task automatic run_row(input bit sel, input int stall_before, input int stall_len, input string name);
    int scale;
    logic [27:0] s;
    scale = sel ? 1 : 3;
    feed(sel, stall_before, stall_len, name);
    model_row(scale, row_pos[sel] == H - 1);
    row_pos[sel] = (row_pos[sel] + 1) % H;
    capture(sel, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s cyc%0d: got v=%0b px=%h fd=%0b rdy=%0b busy=%0b, expected v=%0b px=%h fd=%0b rdy=%0b busy=%0b",
                 name, i, obs_q[i][27], obs_q[i][26:3], obs_q[i][2], obs_q[i][1], obs_q[i][0],
                 exp_q[i][27], exp_q[i][26:3], exp_q[i][2], exp_q[i][1], exp_q[i][0]);
      end
      beats_seen += int'(obs_q[i][27]);
      fd_seen    += int'(obs_q[i][2]);
    end
    @(negedge clk);
    s = sample(sel);
    n_tests++;
    if (s[1] !== 1'b1 || s[27] !== 1'b0 || s[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL %s after: s_ready=%0b valid=%0b busy=%0b, expected 1 0 0", name, s[1], s[27], s[0]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, '0);
    drive(1'b1, 1'b0, '0);
    repeat (5) @(negedge clk);
    n_tests++;
    if ({bus3.output_valid, bus3.pixel_out, bus3.frame_done, bus3.busy} !== 27'd0) begin
      n_fail++;
      $display("FAIL reset_held: v=%0b px=%h fd=%0b busy=%0b, expected all 0",
               bus3.output_valid, bus3.pixel_out, bus3.frame_done, bus3.busy);
    end
    rst_n = 1'b1;
    row_pos[0] = 0;
    row_pos[1] = 0;
    @(negedge clk);
    for (int sel = 0; sel < 2; sel++) begin
      n_tests++;
      if (sample(sel[0]) !== pack(1'b0, 24'h0, 1'b0, 1'b1, 1'b0)) begin
        n_fail++;
        $display("FAIL reset_release%0d: got %h, expected %h", sel, sample(sel[0]), pack(1'b0, 24'h0, 1'b0, 1'b1, 1'b0));
      end
    end
  endtask

  task automatic test_single_row();
    for (int i = 0; i < W; i++) row_px[i] = pix_t'(i + 1);
    beats_seen = 0;
    run_row(1'b0, -1, 0, "single_row");
    n_tests++;
    if (beats_seen !== 36) begin
      n_fail++;
      $display("FAIL single_row_beats: got %0d, expected 36", beats_seen);
    end
  endtask

  task automatic test_input_stall();
    for (int i = 0; i < W; i++) row_px[i] = pix_t'(i + 1);
    run_row(1'b0, 2, 5, "input_stall");
  endtask

  task automatic test_full_frame();
    beats_seen = 0;
    fd_seen    = 0;
    for (int i = 0; i < W; i++) row_px[i] = pix_t'(i + 1);
    run_row(1'b0, -1, 0, "frame_row0");
    for (int i = 0; i < W; i++) row_px[i] = pix_t'(i + 10);
    run_row(1'b0, -1, 0, "frame_row1");
    n_tests++;
    if (beats_seen !== W * H * 9 || fd_seen !== 1) begin
      n_fail++;
      $display("FAIL full_frame: beats=%0d frame_done=%0d, expected %0d and 1", beats_seen, fd_seen, W * H * 9);
    end
  endtask

  task automatic test_random_frames();
    for (int n = 0; n < 2 * H; n++) begin
      for (int i = 0; i < W; i++) row_px[i] = pix_t'($urandom);
      run_row(1'b0, int'($urandom_range(0, W)), int'($urandom_range(1, 4)), "random_row");
    end
  endtask

  task automatic test_reset_mid_emit();
    for (int i = 0; i < W; i++) row_px[i] = pix_t'($urandom);
    feed(1'b0, -1, 0, "mid_emit");
    model_row(3, row_pos[0] == H - 1);
    capture(1'b0, 7);
    for (int i = 0; i < 7; i++) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL mid_emit_pre%0d: got %h, expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus3.output_valid !== 1'b0 || bus3.pixel_out !== 24'h0 || bus3.s_ready !== 1'b1 || bus3.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_emit_async: v=%0b px=%h rdy=%0b busy=%0b, expected 0 0 1 0",
               bus3.output_valid, bus3.pixel_out, bus3.s_ready, bus3.busy);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    row_pos[0] = 0;
    row_pos[1] = 0;
    capture(1'b0, 10);
    for (int i = 0; i < 10; i++) begin
      n_tests++;
      if (obs_q[i] !== pack(1'b0, 24'h0, 1'b0, 1'b1, 1'b0)) begin
        n_fail++;
        $display("FAIL mid_emit_idle%0d: got %h, expected %h", i, obs_q[i], pack(1'b0, 24'h0, 1'b0, 1'b1, 1'b0));
      end
    end
    for (int i = 0; i < W; i++) row_px[i] = pix_t'($urandom);
    run_row(1'b0, -1, 0, "after_reset");
  endtask

  task automatic test_scale1();
    beats_seen = 0;
    fd_seen    = 0;
    for (int i = 0; i < W; i++) row_px[i] = pix_t'((i + 1) * 16);
    run_row(1'b1, -1, 0, "scale1_row0");
    for (int i = 0; i < W; i++) row_px[i] = pix_t'($urandom);
    run_row(1'b1, int'($urandom_range(0, W)), 3, "scale1_row1");
    n_tests++;
    if (beats_seen !== 2 * W || fd_seen !== 1) begin
      n_fail++;
      $display("FAIL scale1_frame: beats=%0d frame_done=%0d, expected %0d and 1", beats_seen, fd_seen, 2 * W);
    end
  endtask

  initial begin
    test_reset();
    test_single_row();
    test_input_stall();
    test_full_frame();
    test_random_frames();
    test_reset_mid_emit();
    test_scale1();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_replicator_tx.md
Name: pixel_replicator_tx

Overview:
Hardware stream source that feeds top_upscaler at native resolution.
- Accepts native-resolution pixels one row at a time over a valid/ready handshake and stores each row in a line buffer.
- Emits each pixel SCALE times horizontally and each row SCALE times vertically, with one idle cycle after every output row.
- The output is the pixel_in/input_valid stream that top_upscaler expects, so the upscaler can be driven in-system without a software pre-expansion step.

Parameters:
- IMG_W, 128, native pixels per row.
- IMG_H, 72, native rows per frame.
- SCALE, 3, replication factor in both axes; must be >= 1.
- PIX_W, 24, bits per pixel (RGB888).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_pixel  in  PIX_W  native input pixel.
- s_valid  in  1  s_pixel is valid.
- s_ready  out  1  block can accept a pixel this cycle.
- pixel_out  out  PIX_W  replicated pixel; connects to top_upscaler pixel_in.
- output_valid  out  1  pixel_out is valid; connects to top_upscaler input_valid.
- frame_done  out  1  one-cycle pulse at the end of each frame.
- busy  out  1  high whenever state is not FILL.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = FILL; col, rep, line and row counters = 0.
  - pixel_out = 0, output_valid = 0, frame_done = 0, busy = 0.
  - s_ready = 1 in the first cycle after release.
  - Line buffer contents are don't-care.
- Handshake: a transfer occurs on a rising edge where s_valid && s_ready. s_ready = 1 only in FILL. s_valid is ignored in all other states.
- FILL state:
  - Each transfer writes s_pixel to buf[col], then col++.
  - On the transfer with col == IMG_W-1: col <= 0, go to EMIT.
  - Stalls indefinitely while s_valid is low. No output is produced in FILL.
- EMIT state:
  - Registered output; the first beat appears one cycle after the edge that accepted the last pixel of the row.
  - Each cycle: pixel_out = buf[col], output_valid = 1.
  - rep counts 0..SCALE-1. When rep wraps, col++.
  - On col == IMG_W-1 with rep == SCALE-1: go to GAP.
- GAP state:
  - Exactly one cycle with output_valid = 0; pixel_out holds its last value.
  - If line < SCALE-1: line++, return to EMIT with col = rep = 0.
  - Otherwise: line <= 0, row++, and go to FILL. frame_done = 1 in this cycle if row == IMG_H-1, and row then wraps to 0.
- No output backpressure: top_upscaler always accepts.
- Cycle counts:
  - Per native row: SCALE*(IMG_W*SCALE+1) output cycles.
  - Per frame: IMG_W*IMG_H*SCALE^2 valid beats.
- Boundary cases:
  - SCALE = 1: pixels pass straight through, with one GAP cycle after each row.
  - Reset asserted mid-EMIT or mid-FILL aborts immediately: output_valid drops asynchronously and the partial row/frame is discarded.
  - Counters are sized with $clog2 of their limits. Wrap occurs only at the stated limits; no counter ever exceeds its limit.
  - busy = 1 in EMIT and GAP.

Decomposition:
- Shared package upscaler_pkg:
  - PIX_W constant and the state enum {FILL, EMIT, GAP}.
  - Helper function for counter widths.
- One sub-module, pixel_line_buffer:
  - IMG_W x PIX_W memory, synchronous write, registered read.
  - Read address is driven one cycle ahead so pixel_out timing is met.

Test Plan (IMG_W=4, IMG_H=2, SCALE=3 unless stated):
- Reset check: hold rst_n low for 5 cycles, then release -> pixel_out = 0, output_valid = 0, frame_done = 0, busy = 0, s_ready = 1.
- Single row: feed 0x000001..0x000004 back-to-back.
  - Expect 01,01,01,02,02,02,03,03,03,04,04,04, then one gap cycle.
  - The sequence repeats 3 times, for 39 cycles total and 36 valid beats.
  - s_ready = 0 throughout.
- Input stall: drop s_valid for 5 cycles between the 2nd and 3rd pixel -> no output_valid until the 4th pixel is accepted; the emitted sequence is identical to the single-row case.
- Full frame: rows {1,2,3,4} and {0xA,0xB,0xC,0xD} -> 72 valid beats.
  - frame_done is high for exactly one cycle, coincident with the final GAP.
  - s_ready = 1 on the next cycle.
- Reset mid-EMIT: assert rst_n low after the 7th beat -> output_valid = 0 and pixel_out = 0 immediately. After release, state is FILL and no stale beats are emitted.
- SCALE=1: feed 0x10,0x20,0x30,0x40 -> output 10,20,30,40 on four consecutive cycles, then one gap cycle, then s_ready = 1.
